pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, elastic pipeline register that replaces the plain reset-to-zero `always_ff` registers between the IF/ID/EX/MEM/WB stages of the pipelined core. It carries one stage-to-stage bundle with a valid/ready handshake, honours hazard-unit stall and flush requests, and can optionally add a skid slot so that `in_ready` is registered and stalls can be propagated without a long combinational path. Saturating event counters expose backpressure and flush activity for performance analysis.

## Interface

Parameters:
- `WIDTH`, 32: bit width of the carried bundle (`$bits` of the stage struct).
- `SKID`, 0: 0 = single slot, with combinational `in_ready`. 1 = two slots (main + skid), with registered `in_ready`.
- `CNT_WIDTH`, 16: width of each performance counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream bundle valid.
- `in_ready`  out  1  stage can accept a bundle this cycle.
- `in_data`  in  WIDTH  upstream bundle.
- `out_valid`  out  1  `out_data` holds a valid bundle.
- `out_ready`  in  1  downstream accepts the bundle.
- `out_data`  out  WIDTH  bundle presented to the next stage.
- `stall`  in  1  hazard-unit stall; blocks acceptance only.
- `flush`  in  1  hazard-unit flush; discards all held bundles.
- `clear_counters`  in  1  synchronous counter clear.
- `occupancy`  out  2  number of valid slots held (0..2).
- `backpressure_cnt`  out  CNT_WIDTH  cycles with `in_valid && !in_ready`.
- `drop_cnt`  out  CNT_WIDTH  number of valid bundles discarded by flush.

## Operation

- **Handshakes.** An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **Outputs from the main slot.** `out_valid` equals the main-slot valid bit. `out_data` equals the main-slot data.
- **SKID=0.**
  - `in_ready = !flush && !stall && (!out_valid || out_ready)`.
  - On an input transfer, the main slot loads `in_data` and its valid bit is set.
  - On an output transfer with no input transfer, the main-slot valid bit clears and the data holds.
- **SKID=1.**
  - `in_ready = !flush && !stall && !skid_valid`. `skid_valid` is a flop, so `in_ready` has no path from `out_ready`.
  - The main slot loads when it is empty or when an output transfer occurs. It loads from the skid slot if that slot is valid, otherwise from the input if an input transfer occurs, otherwise it becomes empty.
  - When an input transfer occurs while the main slot is valid and no output transfer occurs, the bundle goes into the skid slot.
  - When the skid slot drains into the main slot while an input transfer occurs, the input is written to the skid slot. This case is unreachable, because `in_ready=0` whenever the skid slot is valid.
- **Flush.**
  - At the next edge, both valid bits clear and both data registers load `'0` (a bubble).
  - Flush overrides any load in the same cycle, and `in_ready` is 0 while `flush` is asserted.
  - `drop_cnt` increments by `occupancy` (0, 1 or 2), excluding a bundle that leaves through an output transfer in the same cycle.
- **Stall.**
  - `stall` forces `in_ready=0`.
  - The output side keeps draining. A stalled stage with `out_ready=1` therefore empties, so a bubble propagates downstream.
  - `stall` together with `flush`: flush wins.
- **Counters.**
  - Both counters saturate at all-ones.
  - `clear_counters` zeroes them at the next edge and overrides an increment in the same cycle.
  - `backpressure_cnt` increments in every cycle where `in_valid && !in_ready`, including cycles where the cause is stall or flush.
- **Occupancy.** `occupancy = main_valid + skid_valid`. With SKID=0 it never exceeds 1.

## Timing

- **Reset values.** While `reset` is high, asynchronously: both valid bits = 0, both data registers = `'0`, counters = 0. The outputs follow: `out_valid=0`, `out_data='0`, `occupancy=0`, `in_ready=0`.
- **After reset.** After `reset` deasserts, `in_ready` is 1 when `stall` and `flush` are low.
- **Reset mid-operation.** Held bundles are lost and are not counted in `drop_cnt`.
- **Latency.** 1 cycle: a bundle accepted at edge N is presented on `out_*` after edge N.
- **Throughput.** 1 bundle per cycle with `out_ready` held high, for both SKID values.
- **SKID=1 recovery.** After a one-cycle `out_ready` drop under continuous input, the skid slot absorbs exactly one bundle. `in_ready` is low for exactly the cycle after the drop and returns high the cycle after `out_ready` returns.
- **Data hold.** `out_data` holds its last value while `out_valid=0`, except after reset or flush, when it is `'0`.

## Test plan

- **Stream, SKID=0 and SKID=1.** Reset, then drive `in_valid=1` with `in_data`=1,2,3,4 on consecutive cycles and `out_ready=1`. Required: `out_data`=1,2,3,4 one cycle later, with no gaps and `backpressure_cnt=0`.
- **Backpressure, SKID=1.** Stream 1..6 with `out_ready=0` for one cycle when bundle 3 is presented. Required: `occupancy` reaches 2, `in_ready` is low for 1 cycle, the output order is 1..6 with none lost or duplicated, and `backpressure_cnt=1`.
- **Flush with two held bundles.** With SKID=1, `out_ready=0` and 2 held bundles, assert `flush` for one cycle. Required: the next cycle shows `out_valid=0`, `out_data=0`, `occupancy=0` and `drop_cnt=2`, and the input beat offered in the flush cycle is not accepted.
- **Stall while draining.** Hold bundle 0xA with `out_ready=1`, then assert `stall` for 3 cycles with `in_valid=1`. Required: 0xA transfers, then `out_valid=0` for the stall cycles, `backpressure_cnt=3`, and input resumes the cycle after `stall` drops.
- **Counter saturation and clear.** With `CNT_WIDTH=4`, apply 20 backpressure cycles. Required: `backpressure_cnt=15`. Then assert `clear_counters` together with backpressure. Required: 0 on the next cycle.
- **Asynchronous reset mid-stream.** Assert `reset` between edges while `occupancy=2`. Required: all outputs are at their reset values immediately, before the next edge, and `drop_cnt` is unchanged at 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between core stages: valid/ready handshake, hazard stall/flush,
// optional skid slot for a registered in_ready, and saturating backpressure/drop counters.
module pipe_stage_reg #(
  parameter int WIDTH     = 32,
  parameter int SKID      = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 clear_counters,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] backpressure_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             room;
  logic             in_xfer;
  logic             out_xfer;
  logic             bp_event;
  logic [1:0]       drop_amt;
  logic [CNT_WIDTH:0] bp_sum;
  logic [CNT_WIDTH:0] drop_sum;

  // With a skid slot, room depends only on a flop so in_ready never sees out_ready.
  assign room      = (SKID == 0) ? (!main_valid || out_ready) : !skid_valid;
  assign in_ready  = !reset && !flush && !stall && room;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (SKID == 0) begin
      if (in_xfer) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else if (out_xfer) begin
        main_valid <= 1'b0;
      end
    end else begin
      if (!main_valid || out_xfer) begin
        if (skid_valid) begin
          main_data  <= skid_data;
          main_valid <= 1'b1;
          skid_valid <= in_xfer;
          if (in_xfer) begin
            skid_data <= in_data;
          end
        end else if (in_xfer) begin
          main_data  <= in_data;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end
  end

  // A bundle leaving downstream in the flush cycle is delivered, not dropped.
  assign bp_event = in_valid && !in_ready;
  assign drop_amt = flush ? ({1'b0, main_valid && !out_ready} + {1'b0, skid_valid}) : 2'd0;
  assign bp_sum   = {1'b0, backpressure_cnt} + {{CNT_WIDTH{1'b0}}, bp_event};
  assign drop_sum = {1'b0, drop_cnt} + {{(CNT_WIDTH-1){1'b0}}, drop_amt};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      backpressure_cnt <= '0;
      drop_cnt         <= '0;
    end else if (clear_counters) begin
      backpressure_cnt <= '0;
      drop_cnt         <= '0;
    end else begin
      backpressure_cnt <= bp_sum[CNT_WIDTH] ? '1 : bp_sum[CNT_WIDTH-1:0];
      drop_cnt         <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 instances share stimulus; each is compared every
// cycle against a queue-style model, plus directed checks for stream/backpressure/flush/stall/counters/reset.
module tb_pipe_stage_reg;
  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic reset, in_valid, out_ready, stall, flush, clear_counters;
  logic [W-1:0] in_data;

  logic         ir_d  [2];
  logic         ov_d  [2];
  logic [W-1:0] od_d  [2];
  logic [1:0]   occ_d [2];
  logic [CW-1:0] bp_d [2];
  logic [CW-1:0] dr_d [2];

  int checks = 0;
  int errors = 0;

  // Model: each instance is an ordered list of held bundles plus the last bundle shown.
  int           cnt    [2];
  logic [W-1:0] held   [2][2];
  logic [W-1:0] shown  [2];
  int           bp_m   [2];
  int           drop_m [2];

  bit           collect;
  logic [W-1:0] seen1 [$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_WIDTH(CW)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_d[0]), .in_data(in_data),
    .out_valid(ov_d[0]), .out_ready(out_ready), .out_data(od_d[0]), .stall(stall), .flush(flush),
    .clear_counters(clear_counters), .occupancy(occ_d[0]), .backpressure_cnt(bp_d[0]), .drop_cnt(dr_d[0])
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_WIDTH(CW)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_d[1]), .in_data(in_data),
    .out_valid(ov_d[1]), .out_ready(out_ready), .out_data(od_d[1]), .stall(stall), .flush(flush),
    .clear_counters(clear_counters), .occupancy(occ_d[1]), .backpressure_cnt(bp_d[1]), .drop_cnt(dr_d[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_in_ready(input int k);
    bit room;
    room = (k == 0) ? (cnt[0] == 0 || out_ready) : (cnt[1] < 2);
    return !reset && !flush && !stall && room;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; shown[k] = '0; bp_m[k] = 0; drop_m[k] = 0;
      held[k][0] = '0; held[k][1] = '0;
    end
  endtask

  task automatic modelEdge();
    bit ir, inx, outx;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        cnt[k] = 0; shown[k] = '0; bp_m[k] = 0; drop_m[k] = 0;
      end else begin
        ir   = model_in_ready(k);
        inx  = in_valid && ir;
        outx = (cnt[k] > 0) && out_ready;
        if (clear_counters) begin
          bp_m[k] = 0; drop_m[k] = 0;
        end else begin
          if (in_valid && !ir) bp_m[k] = (bp_m[k] + 1 > CMAX) ? CMAX : bp_m[k] + 1;
          if (flush) drop_m[k] = (drop_m[k] + cnt[k] - int'(outx) > CMAX) ? CMAX
                                 : drop_m[k] + cnt[k] - int'(outx);
        end
        if (flush) begin
          cnt[k] = 0; shown[k] = '0;
        end else begin
          if (outx) begin
            held[k][0] = held[k][1];
            cnt[k]--;
          end
          if (inx) begin
            held[k][cnt[k]] = in_data;
            cnt[k]++;
          end
          if (cnt[k] > 0) shown[k] = held[k][0];
        end
      end
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("in_ready[%0d]", k), 32'(ir_d[k]), 32'(model_in_ready(k)));
      check($sformatf("out_valid[%0d]", k), 32'(ov_d[k]), 32'(cnt[k] > 0));
      check($sformatf("out_data[%0d]", k), 32'(od_d[k]), 32'(shown[k]));
      check($sformatf("occupancy[%0d]", k), 32'(occ_d[k]), 32'(cnt[k]));
      check($sformatf("bp_cnt[%0d]", k), 32'(bp_d[k]), 32'(bp_m[k]));
      check($sformatf("drop_cnt[%0d]", k), 32'(dr_d[k]), 32'(drop_m[k]));
    end
    if (collect && ov_d[1] && out_ready) seen1.push_back(od_d[1]);
  endtask

  task automatic applyStimulus(input bit rst, input bit iv, input logic [W-1:0] d, input bit ordy,
                               input bit st, input bit fl, input bit clr);
    reset = rst; in_valid = iv; in_data = d; out_ready = ordy;
    stall = st; flush = fl; clear_counters = clr;
    if (rst) modelReset();
    @(negedge clk);
    checkOutput();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v;
    int max_occ;
    collect = 1'b0;
    modelReset();

    applyStimulus(1, 0, 8'h00, 1, 0, 0, 0);
    applyStimulus(1, 1, 8'h5A, 1, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);

    // Stream 1..4 with out_ready held high.
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, W'(i), 1, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    check("stream_bp0", 32'(bp_d[0]), 32'd0);
    check("stream_bp1", 32'(bp_d[1]), 32'd0);

    // One-cycle out_ready drop while bundle 3 is presented.
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
    v = 1; max_occ = 0; collect = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bit acc;
      acc = (v <= 6) && (cnt[1] < 2);
      applyStimulus(0, v <= 6, W'(v), c != 3, 0, 0, 0);
      if (acc) v++;
      if (int'(occ_d[1]) > max_occ) max_occ = int'(occ_d[1]);
    end
    collect = 1'b0;
    check("bpress_bp1", 32'(bp_d[1]), 32'd1);
    check("bpress_maxocc", 32'(max_occ), 32'd2);
    check("bpress_count", 32'(seen1.size()), 32'd6);
    for (int i = 0; i < seen1.size(); i++) check($sformatf("bpress_order%0d", i), 32'(seen1[i]), 32'(i + 1));

    // Flush with two held bundles in the skid instance.
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
    applyStimulus(0, 1, 8'h11, 0, 0, 0, 0);
    applyStimulus(0, 1, 8'h22, 0, 0, 0, 0);
    applyStimulus(0, 1, 8'h33, 0, 0, 1, 0);
    check("flush_valid", 32'(ov_d[1]), 32'd0);
    check("flush_data", 32'(od_d[1]), 32'd0);
    check("flush_occ", 32'(occ_d[1]), 32'd0);
    check("flush_drop", 32'(dr_d[1]), 32'd2);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);

    // Stall while draining bundle 0xA.
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
    applyStimulus(0, 1, 8'h0A, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h0B, 1, 1, 0, 0);
    check("stall_bp0", 32'(bp_d[0]), 32'd3);
    check("stall_bp1", 32'(bp_d[1]), 32'd3);
    applyStimulus(0, 1, 8'h0B, 1, 0, 0, 0);
    check("stall_resume_occ", 32'(occ_d[1]), 32'd1);
    check("stall_resume_data", 32'(od_d[1]), 32'h0B);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);

    // Counter saturation, then clear racing an increment.
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 8'h77, 1, 1, 0, 0);
    check("sat_bp0", 32'(bp_d[0]), 32'd15);
    check("sat_bp1", 32'(bp_d[1]), 32'd15);
    applyStimulus(0, 1, 8'h77, 1, 1, 0, 1);
    check("clr_bp0", 32'(bp_d[0]), 32'd0);
    check("clr_bp1", 32'(bp_d[1]), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, W'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset between edges with the skid instance full.
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 1);
    applyStimulus(0, 1, 8'h55, 0, 0, 0, 0);
    applyStimulus(0, 1, 8'h66, 0, 0, 0, 0);
    check("pre_reset_occ", 32'(occ_d[1]), 32'd2);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("arst_valid[%0d]", k), 32'(ov_d[k]), 32'd0);
      check($sformatf("arst_data[%0d]", k), 32'(od_d[k]), 32'd0);
      check($sformatf("arst_occ[%0d]", k), 32'(occ_d[k]), 32'd0);
      check($sformatf("arst_ready[%0d]", k), 32'(ir_d[k]), 32'd0);
      check($sformatf("arst_drop[%0d]", k), 32'(dr_d[k]), 32'd0);
    end
    modelReset();
    @(posedge clk); #1;
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);
    applyStimulus(0, 1, 8'h42, 1, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
